// File: rtl/amo_pkg.sv
// Shared definitions for the atomic memory controller: funct5 codes, FSM encoding
// and the decode helper that separates supported atomics from unknown ones.
package amo_pkg;

   localparam logic [4:0] FN5_AMOADD = 5'b00000;
   localparam logic [4:0] FN5_SWAP   = 5'b00001;
   localparam logic [4:0] FN5_LR     = 5'b00010;
   localparam logic [4:0] FN5_SC     = 5'b00011;
   localparam logic [4:0] FN5_XOR    = 5'b00100;
   localparam logic [4:0] FN5_OR     = 5'b01000;
   localparam logic [4:0] FN5_AND    = 5'b01100;
   localparam logic [4:0] FN5_MIN    = 5'b10000;
   localparam logic [4:0] FN5_MAX    = 5'b10100;
   localparam logic [4:0] FN5_MINU   = 5'b11000;
   localparam logic [4:0] FN5_MAXU   = 5'b11100;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PLAIN  = 3'd1;
   localparam logic [2:0] ST_LR_RD  = 3'd2;
   localparam logic [2:0] ST_SC_WR  = 3'd3;
   localparam logic [2:0] ST_AMO_RD = 3'd4;
   localparam logic [2:0] ST_AMO_WR = 3'd5;
   localparam logic [2:0] ST_RESP   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_PLAIN  = ST_PLAIN,
      S_LR_RD  = ST_LR_RD,
      S_SC_WR  = ST_SC_WR,
      S_AMO_RD = ST_AMO_RD,
      S_AMO_WR = ST_AMO_WR,
      S_RESP   = ST_RESP
   } state_t;

   function automatic logic fn5_known(input logic [4:0] f);
      case (f)
         FN5_AMOADD, FN5_SWAP, FN5_LR, FN5_SC, FN5_XOR, FN5_OR, FN5_AND,
         FN5_MIN, FN5_MAX, FN5_MINU, FN5_MAXU: fn5_known = 1'b1;
         default:                              fn5_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO result: combines the old memory word with the request operand.
module amo_alu
   import amo_pkg::*;
(
   input  logic [4:0]  funct5,
   input  logic [31:0] old_val,
   input  logic [31:0] operand,
   output logic [31:0] result
);

   always_comb begin
      result = operand;
      case (funct5)
         FN5_AMOADD: result = old_val + operand;
         FN5_SWAP:   result = operand;
         FN5_XOR:    result = old_val ^ operand;
         FN5_OR:     result = old_val | operand;
         FN5_AND:    result = old_val & operand;
         FN5_MIN:    result = ($signed(old_val) < $signed(operand)) ? old_val : operand;
         FN5_MAX:    result = ($signed(old_val) > $signed(operand)) ? old_val : operand;
         FN5_MINU:   result = (old_val < operand) ? old_val : operand;
         FN5_MAXU:   result = (old_val > operand) ? old_val : operand;
         default:    result = operand;
      endcase
   end

endmodule

// File: rtl/amo_mem_ctrl.sv
// Serializing memory controller: forwards plain accesses, runs LR/SC against a
// per-id reservation table and turns AMOs into a locked read-modify-write.
module amo_mem_ctrl
   import amo_pkg::*;
#(
   parameter  int N_IDS = 2,
   localparam int ID_W  = (N_IDS > 1) ? $clog2(N_IDS) : 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_bus_en,
   input  logic            i_wr_en,
   input  logic [31:0]     i_wr_data,
   input  logic [31:0]     i_addr,
   input  logic [3:0]      i_byte_en,
   input  logic            i_atomic,
   input  logic [ID_W-1:0] i_id,
   input  logic [6:0]      i_operation,
   output logic            o_ack,
   output logic [31:0]     o_rd_data,
   input  logic            i_ack,
   input  logic [31:0]     i_rd_data,
   output logic            o_bus_en,
   output logic            o_wr_en,
   output logic [31:0]     o_wr_data,
   output logic [31:0]     o_addr,
   output logic [3:0]      o_byte_en
);

   state_t            state, state_n;
   logic [4:0]        op_q, op_n;
   logic [ID_W-1:0]   id_q, id_n;
   logic [31:0]       opnd_q, opnd_n, old_q, old_n;
   logic              ack_n, bus_n, wr_n;
   logic [31:0]       rd_n, wdata_n, addr_n;
   logic [3:0]        be_n;

   logic [N_IDS-1:0]        res_vld;
   logic [N_IDS-1:0][29:0]  res_addr;
   logic                    res_set, res_clr_own, st_clr;

   logic [4:0]  fn5;
   logic        id_ok, is_atom, is_lr, is_sc, is_amo, res_hit;
   logic [31:0] alu_res;
   logic        unused_op;

   assign fn5       = i_operation[6:2];
   assign unused_op = ^i_operation[1:0];
   assign id_ok     = int'(i_id) < N_IDS;
   assign is_atom   = i_atomic && id_ok && fn5_known(fn5);
   assign is_lr     = is_atom && (fn5 == FN5_LR);
   assign is_sc     = is_atom && (fn5 == FN5_SC);
   assign is_amo    = is_atom && !is_lr && !is_sc;
   assign res_hit   = id_ok && res_vld[i_id] && (res_addr[i_id] == i_addr[31:2]);

   amo_alu u_alu (
      .funct5  (op_q),
      .old_val (i_rd_data),
      .operand (opnd_q),
      .result  (alu_res)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         op_q      <= '0;
         id_q      <= '0;
         opnd_q    <= '0;
         old_q     <= '0;
         o_ack     <= 1'b0;
         o_rd_data <= '0;
         o_bus_en  <= 1'b0;
         o_wr_en   <= 1'b0;
         o_wr_data <= '0;
         o_addr    <= '0;
         o_byte_en <= '0;
      end else begin
         state     <= state_n;
         op_q      <= op_n;
         id_q      <= id_n;
         opnd_q    <= opnd_n;
         old_q     <= old_n;
         o_ack     <= ack_n;
         o_rd_data <= rd_n;
         o_bus_en  <= bus_n;
         o_wr_en   <= wr_n;
         o_wr_data <= wdata_n;
         o_addr    <= addr_n;
         o_byte_en <= be_n;
      end
   end

   always_comb begin
      state_n     = state;
      op_n        = op_q;
      id_n        = id_q;
      opnd_n      = opnd_q;
      old_n       = old_q;
      ack_n       = 1'b0;
      rd_n        = o_rd_data;
      bus_n       = o_bus_en;
      wr_n        = o_wr_en;
      wdata_n     = o_wr_data;
      addr_n      = o_addr;
      be_n        = o_byte_en;
      res_set     = 1'b0;
      res_clr_own = 1'b0;
      st_clr      = 1'b0;
      case (state)
         S_IDLE: if (i_bus_en) begin
            id_n   = i_id;
            op_n   = fn5;
            opnd_n = i_wr_data;
            addr_n = {i_addr[31:2], 2'b00};
            be_n   = 4'hF;
            if (is_lr) begin
               state_n = S_LR_RD;
               bus_n   = 1'b1;
               wr_n    = 1'b0;
            end else if (is_sc) begin
               // An SC always consumes its own reservation, pass or fail.
               res_clr_own = 1'b1;
               if (res_hit) begin
                  state_n = S_SC_WR;
                  bus_n   = 1'b1;
                  wr_n    = 1'b1;
                  wdata_n = i_wr_data;
               end else begin
                  state_n = S_RESP;
                  ack_n   = 1'b1;
                  rd_n    = 32'd1;
               end
            end else if (is_amo) begin
               state_n = S_AMO_RD;
               bus_n   = 1'b1;
               wr_n    = 1'b0;
            end else begin
               state_n = S_PLAIN;
               bus_n   = 1'b1;
               wr_n    = i_wr_en;
               wdata_n = i_wr_data;
               addr_n  = i_addr;
               be_n    = i_byte_en;
            end
         end
         S_PLAIN: if (i_ack) begin
            state_n = S_RESP;
            bus_n   = 1'b0;
            wr_n    = 1'b0;
            ack_n   = 1'b1;
            rd_n    = o_wr_en ? 32'd0 : i_rd_data;
            st_clr  = o_wr_en;
         end
         S_LR_RD: if (i_ack) begin
            state_n = S_RESP;
            bus_n   = 1'b0;
            ack_n   = 1'b1;
            rd_n    = i_rd_data;
            res_set = 1'b1;
         end
         S_SC_WR: if (i_ack) begin
            state_n = S_RESP;
            bus_n   = 1'b0;
            wr_n    = 1'b0;
            ack_n   = 1'b1;
            rd_n    = 32'd0;
            st_clr  = 1'b1;
         end
         // Bus stays requested across the read->write turn so nothing can slip in.
         S_AMO_RD: if (i_ack) begin
            state_n = S_AMO_WR;
            old_n   = i_rd_data;
            wr_n    = 1'b1;
            wdata_n = alu_res;
         end
         S_AMO_WR: if (i_ack) begin
            state_n = S_RESP;
            bus_n   = 1'b0;
            wr_n    = 1'b0;
            ack_n   = 1'b1;
            rd_n    = old_q;
            st_clr  = 1'b1;
         end
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   for (genvar k = 0; k < N_IDS; k++) begin : g_res
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            res_vld[k]  <= 1'b0;
            res_addr[k] <= '0;
         end else if (res_set && int'(id_q) == k) begin
            res_vld[k]  <= 1'b1;
            res_addr[k] <= o_addr[31:2];
         end else if ((res_clr_own && int'(i_id) == k) ||
                      (st_clr && res_addr[k] == o_addr[31:2])) begin
            res_vld[k]  <= 1'b0;
         end
      end
   end

endmodule
